// File: rtl/mem_stage_access_ctrl_if.sv
// Data-bus bundle between the M-stage access controller (master) and memory (slave).
// Request/ready handshake: the master holds bus_req and the request fields until the
// slave answers with bus_ready; bus_rdata is valid in that same cycle.
interface mem_stage_access_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [3:0]        bus_be;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic              bus_ready;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/mem_stage_access_ctrl.sv
// M-stage memory access controller: decodes loads/stores/mfc0/mtc0, runs one bus
// transaction per access (IDLE -> BUSY -> DONE), stalls the pipeline while it is
// outstanding, extends load data and raises address-error exceptions.
// Optional feature: define BUS_TIMEOUT_EN to abandon a transaction after TIMEOUT_CYC
// BUSY cycles without bus_ready and report a bus error (code 7).
module mem_stage_access_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             instr_m,
  input  logic                    valid_m,
  input  logic                    flush,
  input  logic [ADDR_W-1:0]       addr_m,
  input  logic [31:0]             wdata_m,
  mem_stage_access_ctrl_if.master bus,
  output logic                    stall_m,
  output logic [31:0]             rdata_m,
  output logic [1:0]              rd_sel,
  output logic                    cp0_we,
  output logic                    exc_valid,
  output logic [4:0]              exc_code,
  output logic [ADDR_W-1:0]       badvaddr
);

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [5:0]        op;
  logic [4:0]        rs;
  logic              is_load, is_store, is_mfc0, is_mtc0, ld_signed, aligned;
  logic              launch, misalign;
  logic [1:0]        sz;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       ld_ext;
  logic              tmo_hit, tmo_flag;

  logic              req_q, we_q, sgn_q;
  logic [3:0]        be_q;
  logic [1:0]        sz_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q;

  logic              unused_instr;
  assign unused_instr = ^instr_m[20:0];

  assign op = instr_m[31:26];
  assign rs = instr_m[25:21];

  // Opcode decode: access kind, size and signedness.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    ld_signed = 1'b0;
    sz        = SzByte;
    case (op)
      6'b100011: begin is_load  = 1'b1; sz = SzWord;                   end
      6'b100001: begin is_load  = 1'b1; sz = SzHalf; ld_signed = 1'b1; end
      6'b100101: begin is_load  = 1'b1; sz = SzHalf;                   end
      6'b100000: begin is_load  = 1'b1; sz = SzByte; ld_signed = 1'b1; end
      6'b100100: begin is_load  = 1'b1; sz = SzByte;                   end
      6'b101011: begin is_store = 1'b1; sz = SzWord;                   end
      6'b101001: begin is_store = 1'b1; sz = SzHalf;                   end
      6'b101000: begin is_store = 1'b1; sz = SzByte;                   end
      default: ;
    endcase
  end

  assign is_mfc0 = (op == 6'b010000) && (rs == 5'b00000);
  assign is_mtc0 = (op == 6'b010000) && (rs == 5'b00100);

  assign aligned  = (sz == SzWord) ? (addr_m[1:0] == 2'b00) :
                    (sz == SzHalf) ? !addr_m[0] : 1'b1;
  // Only IDLE may launch or fault; in BUSY/DONE the same instruction is still held in M.
  assign launch   = (state_q == StIdle) && valid_m && !flush && (is_load || is_store) && aligned;
  assign misalign = (state_q == StIdle) && valid_m && !flush && (is_load || is_store) && !aligned;

  // Byte enables and lane-replicated store data for the access about to launch.
  always_comb begin
    be_d    = 4'b0001 << addr_m[1:0];
    wdata_d = {4{wdata_m[7:0]}};
    case (sz)
      SzWord: begin be_d = 4'b1111; wdata_d = wdata_m; end
      SzHalf: begin be_d = addr_m[1] ? 4'b1100 : 4'b0011; wdata_d = {2{wdata_m[15:0]}}; end
      default: ;
    endcase
  end

  // Lane select and sign/zero extension of the returning read word.
  always_comb begin
    lane_b = bus.bus_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (sz_q)
      SzWord:  ld_ext = bus.bus_rdata;
      SzHalf:  ld_ext = {{16{sgn_q & lane_h[15]}}, lane_h};
      default: ld_ext = {{24{sgn_q & lane_b[7]}}, lane_b};
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] cnt_q;
  logic            to_q;

  assign tmo_hit  = (state_q == StBusy) && !bus.bus_ready && (cnt_q == CntW'(TIMEOUT_CYC - 1));
  assign tmo_flag = to_q;

  // BUSY-cycle counter; to_q marks the DONE cycle that follows a timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      if (launch) begin
        cnt_q <= '0;
      end else if (state_q == StBusy) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      to_q <= tmo_hit;
    end
  end
`else
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;

  assign tmo_hit  = 1'b0;
  assign tmo_flag = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (launch) state_d = StBusy;
      StBusy:  if (bus.bus_ready || tmo_hit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request latch at launch; capture (or clear on timeout) when BUSY ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sz_q    <= SzByte;
      sgn_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        StIdle: if (launch) begin
          req_q   <= 1'b1;
          we_q    <= is_store;
          be_q    <= be_d;
          addr_q  <= addr_m;
          wdata_q <= wdata_d;
          sz_q    <= sz;
          sgn_q   <= ld_signed;
        end
        StBusy: if (bus.bus_ready) begin
          req_q   <= 1'b0;
          rdata_q <= ld_ext;
        end else if (tmo_hit) begin
          req_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs: stall, exceptions, writeback select and CP0 strobe.
  always_comb begin
    stall_m   = launch || (state_q == StBusy);
    exc_valid = 1'b0;
    exc_code  = 5'd0;
    badvaddr  = '0;
    if (misalign) begin
      exc_valid = 1'b1;
      exc_code  = is_load ? 5'd4 : 5'd5;
      badvaddr  = addr_m;
    end else if ((state_q == StDone) && tmo_flag) begin
      exc_valid = 1'b1;
      exc_code  = 5'd7;
      badvaddr  = addr_q;
    end
    rd_sel = 2'b00;
    if (valid_m && is_mfc0)      rd_sel = 2'b01;
    else if (valid_m && is_load) rd_sel = 2'b10;
    cp0_we = valid_m && is_mtc0 && !flush;
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.bus_wdata = wdata_q;
  assign rdata_m       = rdata_q;

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Self-checking bench for mem_stage_access_ctrl: directed cases plus randomized
// accesses checked against an arithmetic model of lane placement and extension.
module tb_mem_stage_access_ctrl;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 4;

  // lw lh lhu lb lbu sw sh sb
  localparam logic [5:0] OPS     [8] = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2B, 6'h29, 6'h28};
  localparam int         OP_SIZE [8] = '{4, 2, 2, 1, 1, 4, 2, 1};
  localparam bit         OP_LOAD [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
  localparam bit         OP_SGN  [8] = '{0, 1, 0, 1, 0, 0, 0, 0};

  logic          clk;
  logic          reset;
  logic [31:0]   instr_m;
  logic          valid_m;
  logic          flush;
  logic [AW-1:0] addr_m;
  logic [31:0]   wdata_m;
  logic          stall_m;
  logic [31:0]   rdata_m;
  logic [1:0]    rd_sel;
  logic          cp0_we;
  logic          exc_valid;
  logic [4:0]    exc_code;
  logic [AW-1:0] badvaddr;

  int n_vec = 0;
  int n_err = 0;

  mem_stage_access_ctrl_if #(.ADDR_W(AW)) bus_if ();

  mem_stage_access_ctrl #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr_m   (instr_m),
    .valid_m   (valid_m),
    .flush     (flush),
    .addr_m    (addr_m),
    .wdata_m   (wdata_m),
    .bus       (bus_if),
    .stall_m   (stall_m),
    .rdata_m   (rdata_m),
    .rd_sel    (rd_sel),
    .cp0_we    (cp0_we),
    .exc_valid (exc_valid),
    .exc_code  (exc_code),
    .badvaddr  (badvaddr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference model: little-endian lane arithmetic.
  function automatic logic [31:0] model_load(int size, bit sgn, logic [31:0] word, int off);
    logic [31:0] v;
    v = word >> (8 * off);
    if (size == 1) begin
      v = v % 256;
      if (sgn && v >= 128) v = v - 256;
    end else if (size == 2) begin
      v = v % 65536;
      if (sgn && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(int size, int off);
    if (size == 4) return 4'hF;
    if (size == 2) return 4'(3 << off);
    return 4'(1 << off);
  endfunction

  function automatic logic [31:0] model_wdata(int size, logic [31:0] wd);
    if (size == 4) return wd;
    if (size == 2) return (wd % 65536) * 32'h0001_0001;
    return (wd % 256) * 32'h0101_0101;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete aligned access; bus_ready arrives in BUSY cycle `delay`.
  task automatic run_access(input int idx, input logic [31:0] addr, input logic [31:0] wd,
                            input int delay, input logic [31:0] rword, input bit flush_busy);
    int          size, off, stalls;
    logic        ld;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd;
    size = OP_SIZE[idx];
    ld   = OP_LOAD[idx];
    off  = int'(addr % 4);
    e_be = model_be(size, off);
    e_wd = model_wdata(size, wd);
    e_rd = model_load(size, OP_SGN[idx], rword, off);
    instr_m = {OPS[idx], 26'($urandom)};
    addr_m  = addr;
    wdata_m = wd;
    valid_m = 1'b1;
    flush   = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({stall_m, bus_if.bus_req, exc_valid, cp0_we} !== 4'b1000) begin
      n_err++;
      $display("FAIL idle_launch op=%h addr=%h got=%b want=1000", OPS[idx], addr,
               {stall_m, bus_if.bus_req, exc_valid, cp0_we});
    end
    stalls = int'(stall_m);
    tick();
    flush = flush_busy;
    for (int k = 1; k <= delay; k++) begin
      bus_if.bus_ready = (k == delay);
      bus_if.bus_rdata = (k == delay) ? rword : $urandom;
      @(negedge clk);
      n_vec++;
      if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_be, bus_if.bus_addr, exc_valid} !==
          {1'b1, ~ld, e_be, (addr & ~32'h3), 1'b0}) begin
        n_err++;
        $display("FAIL bus_ctrl op=%h addr=%h got req=%b we=%b be=%b a=%h exc=%b want we=%b be=%b",
                 OPS[idx], addr, bus_if.bus_req, bus_if.bus_we, bus_if.bus_be, bus_if.bus_addr,
                 exc_valid, ~ld, e_be);
      end
      if (!ld) begin
        n_vec++;
        if (bus_if.bus_wdata !== e_wd) begin
          n_err++;
          $display("FAIL bus_wdata op=%h got=%h want=%h", OPS[idx], bus_if.bus_wdata, e_wd);
        end
      end
      stalls += int'(stall_m);
      tick();
      bus_if.bus_ready = 1'b0;
    end
    flush = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({stall_m, bus_if.bus_req, exc_valid, rd_sel} !== {3'b000, (ld ? 2'b10 : 2'b00)}) begin
      n_err++;
      $display("FAIL done_state op=%h got stall=%b req=%b exc=%b rd_sel=%b", OPS[idx], stall_m,
               bus_if.bus_req, exc_valid, rd_sel);
    end
    n_vec++;
    if (stalls !== delay + 1) begin
      n_err++;
      $display("FAIL stall_cycles op=%h got=%0d want=%0d", OPS[idx], stalls, delay + 1);
    end
    if (ld) begin
      n_vec++;
      if (rdata_m !== e_rd) begin
        n_err++;
        $display("FAIL rdata_m op=%h addr=%h word=%h got=%h want=%h", OPS[idx], addr, rword,
                 rdata_m, e_rd);
      end
    end
    tick();
    valid_m = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_m = 1'b0; flush = 1'b0;
    instr_m = '0; addr_m = '0; wdata_m = '0;
    bus_if.bus_ready = 1'b0; bus_if.bus_rdata = '0;
    repeat (2) tick();
    @(negedge clk);
    n_vec++;
    if ({bus_if.bus_req, stall_m, rdata_m} !== '0) begin
      n_err++;
      $display("FAIL reset_hold got req=%b stall=%b rdata=%h want 0", bus_if.bus_req, stall_m,
               rdata_m);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_be, bus_if.bus_addr, bus_if.bus_wdata,
         stall_m, rdata_m, exc_valid, cp0_we} !== '0) begin
      n_err++;
      $display("FAIL reset_state got req=%b be=%b addr=%h wd=%h stall=%b rd=%h exc=%b want 0",
               bus_if.bus_req, bus_if.bus_be, bus_if.bus_addr, bus_if.bus_wdata, stall_m,
               rdata_m, exc_valid);
    end
    tick();
  endtask

  task automatic test_directed();
    run_access(0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0);
    run_access(6, 32'h102, 32'h0000ABCD, 1, 32'h0, 1'b0);
    run_access(3, 32'h103, 32'h0, 1, 32'h80123456, 1'b0);
    run_access(4, 32'h103, 32'h0, 1, 32'h80123456, 1'b0);
  endtask

  task automatic test_random_access();
    for (int i = 0; i < 40; i++) begin
      int          idx, size;
      logic [31:0] a;
      idx  = $urandom_range(0, 7);
      size = OP_SIZE[idx];
      a    = $urandom;
      a    = a - (a % size);
      run_access(idx, a, $urandom, $urandom_range(1, 4), $urandom, 1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      int          idx;
      logic [31:0] a;
      idx = $urandom_range(0, 7);
      a   = $urandom;
      a   = a - (a % OP_SIZE[idx]);
      run_access(idx, a, $urandom, 1, $urandom, 1'b0);
    end
  endtask

  task automatic test_misaligned();
    int pick [5] = '{0, 1, 2, 5, 6};
    for (int i = 0; i < 18; i++) begin
      int          idx;
      logic [31:0] a, r;
      bit          fl;
      logic [4:0]  e_code;
      if (i == 0) begin
        idx = 0; a = 32'h106; fl = 1'b0;
      end else if (i == 1) begin
        idx = 6; a = 32'h101; fl = 1'b0;
      end else begin
        idx = pick[$urandom_range(0, 4)];
        r   = $urandom;
        a   = (OP_SIZE[idx] == 4) ? ({r[31:2], 2'b00} + 32'($urandom_range(1, 3))) : (r | 32'h1);
        fl  = ($urandom_range(0, 3) == 0);
      end
      e_code  = OP_LOAD[idx] ? 5'd4 : 5'd5;
      instr_m = {OPS[idx], 26'($urandom)};
      addr_m  = a;
      valid_m = 1'b1;
      flush   = fl;
      @(negedge clk);
      n_vec++;
      if ({stall_m, bus_if.bus_req, exc_valid} !== {2'b00, ~fl}) begin
        n_err++;
        $display("FAIL misalign_flags op=%h addr=%h flush=%b got stall=%b req=%b exc=%b",
                 OPS[idx], a, fl, stall_m, bus_if.bus_req, exc_valid);
      end
      if (!fl) begin
        n_vec++;
        if ({exc_code, badvaddr} !== {e_code, a}) begin
          n_err++;
          $display("FAIL misalign_code op=%h got code=%0d bad=%h want code=%0d bad=%h",
                   OPS[idx], exc_code, badvaddr, e_code, a);
        end
      end
      tick();
      valid_m = 1'b0;
      flush   = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({bus_if.bus_req, stall_m, exc_valid} !== 3'b000) begin
        n_err++;
        $display("FAIL misalign_no_launch got req=%b stall=%b exc=%b want 000", bus_if.bus_req,
                 stall_m, exc_valid);
      end
      tick();
    end
  endtask

  task automatic test_flush_idle();
    for (int i = 0; i < 6; i++) begin
      int          idx;
      logic [31:0] a;
      idx = $urandom_range(0, 7);
      a   = $urandom;
      a   = a - (a % OP_SIZE[idx]);
      instr_m = {OPS[idx], 26'($urandom)};
      addr_m  = a;
      valid_m = 1'b1;
      flush   = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({stall_m, exc_valid} !== 2'b00) begin
        n_err++;
        $display("FAIL flush_idle op=%h got stall=%b exc=%b want 00", OPS[idx], stall_m, exc_valid);
      end
      tick();
      valid_m = 1'b0;
      flush   = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus_if.bus_req !== 1'b0) begin
        n_err++;
        $display("FAIL flush_no_req got=%b want 0", bus_if.bus_req);
      end
      tick();
    end
  endtask

  task automatic test_cp0();
    for (int i = 0; i < 24; i++) begin
      int         kind;
      bit         v, fl;
      logic [4:0] rs;
      logic [5:0] op;
      logic       e_we;
      logic [1:0] e_sel;
      kind = $urandom_range(0, 2);
      v    = ($urandom_range(0, 3) != 0);
      fl   = 1'($urandom);
      op   = (kind == 2) ? 6'h00 : 6'h10;
      rs   = (kind == 0) ? 5'd0 : (kind == 1) ? 5'd4 : 5'($urandom);
      instr_m = {op, rs, 21'($urandom)};
      valid_m = v;
      flush   = fl;
      e_we    = v && (kind == 1) && !fl;
      e_sel   = (kind == 0) ? 2'b01 : 2'b00;
      @(negedge clk);
      n_vec++;
      if ({cp0_we, stall_m, exc_valid} !== {e_we, 2'b00}) begin
        n_err++;
        $display("FAIL cp0_we kind=%0d valid=%b flush=%b got we=%b stall=%b exc=%b want we=%b",
                 kind, v, fl, cp0_we, stall_m, exc_valid, e_we);
      end
      if (v) begin
        n_vec++;
        if (rd_sel !== e_sel) begin
          n_err++;
          $display("FAIL rd_sel_cp0 kind=%0d got=%b want=%b", kind, rd_sel, e_sel);
        end
      end
      tick();
    end
    valid_m = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    run_access(0, 32'h40, 32'h0, 1, 32'h12345678, 1'b0);
    instr_m = {OPS[0], 26'd0};
    addr_m  = 32'h44;
    valid_m = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_vec++;
    if ({stall_m, bus_if.bus_req} !== 2'b11) begin
      n_err++;
      $display("FAIL busy_before_reset got stall=%b req=%b want 11", stall_m, bus_if.bus_req);
    end
    reset   = 1'b1;
    valid_m = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus_if.bus_req, stall_m, exc_valid, rdata_m} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_busy got req=%b stall=%b exc=%b rd=%h want 0", bus_if.bus_req,
               stall_m, exc_valid, rdata_m);
    end
    tick();
    run_access(0, 32'h48, 32'h0, 2, 32'hCAFEF00D, 1'b0);
  endtask

  task automatic test_timeout();
    run_access(0, 32'h1F0, 32'h0, 1, 32'hA5A5A5A5, 1'b0);
`ifdef BUS_TIMEOUT_EN
    instr_m = {OPS[0], 26'd0};
    addr_m  = 32'h200;
    valid_m = 1'b1;
    for (int k = 0; k <= int'(TO); k++) begin
      @(negedge clk);
      n_vec++;
      if ({stall_m, exc_valid} !== 2'b10) begin
        n_err++;
        $display("FAIL timeout_wait cycle=%0d got stall=%b exc=%b want 10", k, stall_m, exc_valid);
      end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if ({exc_valid, exc_code, badvaddr, stall_m, bus_if.bus_req, rdata_m} !==
        {1'b1, 5'd7, 32'h200, 1'b0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL timeout_done got exc=%b code=%0d bad=%h stall=%b req=%b rd=%h", exc_valid,
               exc_code, badvaddr, stall_m, bus_if.bus_req, rdata_m);
    end
    tick();
    valid_m = 1'b0;
    @(negedge clk);
    n_vec++;
    if (exc_valid !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_clear got exc=%b want 0", exc_valid);
    end
    tick();
`else
    // Without the timeout the controller must keep waiting and never report code 7.
    run_access(0, 32'h200, 32'h0, 20, 32'h0BADF00D, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misaligned();
    test_flush_idle();
    test_cp0();
    test_random_access();
    test_back_to_back();
    test_reset_mid_busy();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
